// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter for one shared W-bit register: IDLE -> GRANT -> HOLD, one write per 3 cycles.
// Optional grant statistics counter enabled by defining ARB_STATS_EN.
module reg_write_arbiter #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           CLK,
    input  logic           n_res,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   gnt,
    output logic [W-1:0]   Q,
    output logic           busy
`ifdef ARB_STATS_EN
    ,
    output logic [15:0]    gnt_cnt
`endif
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    // Pointer starts at the last requester so requester 0 wins first after reset.
    localparam logic [PW-1:0] PTR_RESET = PW'(N - 1);

    logic [1:0]    state_q,  state_d;
    logic [PW-1:0] ptr_q,    ptr_d;
    logic [PW-1:0] winner_q, winner_d;
    logic [N-1:0]  gnt_q,    gnt_d;
    logic [W-1:0]  q_q,      q_d;
    logic          busy_q,   busy_d;

    logic [PW-1:0] pick;
    logic          pick_valid;
    logic [PW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pick       = '0;
        pick_valid = 1'b0;
        cand       = '0;
        for (int off = N; off >= 1; off--) begin
            cand = PW'((int'(ptr_q) + off) % N);
            if (req[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        winner_d = winner_q;
        gnt_d    = '0;
        q_d      = q_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    winner_d    = pick;
                    gnt_d[pick] = 1'b1;
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Winner data is taken only here, whether or not req is still high.
                q_d     = wdata[int'(winner_q)*W +: W];
                ptr_d   = winner_q;
                state_d = HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            state_q  <= IDLE;
            ptr_q    <= PTR_RESET;
            winner_q <= '0;
            gnt_q    <= '0;
            q_q      <= '0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            winner_q <= winner_d;
            gnt_q    <= gnt_d;
            q_q      <= q_d;
            busy_q   <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign Q    = q_q;
    assign busy = busy_q;

`ifdef ARB_STATS_EN
    logic [15:0] cnt_q;

    // Counts completed writes; wraps naturally at 16 bits.
    always_ff @(posedge CLK or negedge n_res) begin
        if (!n_res) begin
            cnt_q <= '0;
        end else if (state_q == GRANT) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter (N=4, W=8): reset, single write, round-robin,
// mid-grant reset, early drop, contention and optional grant counter.
`timescale 1ps/1ps
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           CLK = 1'b0;
    logic           n_res;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [W-1:0]   Q;
    logic           busy;
`ifdef ARB_STATS_EN
    logic [15:0]    gnt_cnt;
`endif

    int checks = 0;
    int passes = 0;

    reg_write_arbiter #(.N(N), .W(W)) dut (
        .CLK   (CLK),
        .n_res (n_res),
        .req   (req),
        .wdata (wdata),
        .gnt   (gnt),
        .Q     (Q),
        .busy  (busy)
`ifdef ARB_STATS_EN
        ,
        .gnt_cnt (gnt_cnt)
`endif
    );

    always #50 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Sample 11ps after the active edge.
    task automatic tick();
        @(posedge CLK);
        #11;
    endtask

    int rr_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        // 1: reset with random inputs, no clock edge yet
        n_res = 1'b0;
        req   = N'($urandom);
        wdata = $urandom;
        #5;
        check("reset_q",    32'(Q),    32'h00);
        check("reset_gnt",  32'(gnt),  32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        @(negedge CLK);
        req   = '0;
        wdata = '0;
        n_res = 1'b1;
        tick();
        check("idle_gnt",  32'(gnt),  32'h0);
        check("idle_busy", 32'(busy), 32'h0);

        // 2: single write from requester 2
        @(negedge CLK);
        req            = 4'b0100;
        wdata[2*W +: W] = 8'hA5;
        tick();
        check("single_gnt",      32'(gnt),  32'h4);
        check("single_busy",     32'(busy), 32'h1);
        check("single_q_before", 32'(Q),    32'h00);
        tick();
        check("single_q",       32'(Q),    32'hA5);
        check("single_gnt_off", 32'(gnt),  32'h0);
        check("single_hold",    32'(busy), 32'h1);
        @(negedge CLK);
        req = '0;
        tick();
        check("single_idle", 32'(busy), 32'h0);
        tick();
        check("single_no_regrant", 32'(gnt), 32'h0);
        check("single_q_kept",     32'(Q),   32'hA5);

        // 3: reset, then all four requesting continuously
        @(negedge CLK);
        n_res = 1'b0;
        #1;
        check("rst2_q", 32'(Q), 32'h00);
        #10;
        n_res = 1'b1;
        req   = 4'b1111;
        wdata = {8'h13, 8'h12, 8'h11, 8'h10};
        for (int t = 0; t < 5; t++) begin
            tick();
            check($sformatf("rr_gnt%0d", t), 32'(gnt), 32'(1 << rr_order[t]));
            tick();
            check($sformatf("rr_q%0d", t),   32'(Q),   32'(8'h10 + rr_order[t]));
            check($sformatf("rr_off%0d", t), 32'(gnt), 32'h0);
            tick();
            check($sformatf("rr_idle%0d", t), 32'(busy), 32'h0);
        end
        @(negedge CLK);
        req = '0;
`ifdef ARB_STATS_EN
        check("stats_cnt5", 32'(gnt_cnt), 32'd5);
`endif

        // 4: reset pulse in the middle of GRANT
        @(negedge CLK);
        req             = 4'b0010;
        wdata[1*W +: W] = 8'hFF;
        tick();
        check("midrst_gnt", 32'(gnt), 32'h2);
        #9;
        n_res = 1'b0;
        req   = '0;
        #5;
        check("midrst_q",    32'(Q),    32'h00);
        check("midrst_gnt0", 32'(gnt),  32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
`ifdef ARB_STATS_EN
        check("stats_cnt0", 32'(gnt_cnt), 32'd0);
`endif
        #10;
        n_res = 1'b1;
        tick();
        check("midrst_no_write", 32'(Q),    32'h00);
        check("midrst_no_gnt",   32'(gnt),  32'h0);
        check("midrst_idle",     32'(busy), 32'h0);

        // 5: winner drops req during GRANT; data changed before the closing edge
        @(negedge CLK);
        req             = 4'b1000;
        wdata[3*W +: W] = 8'h5C;
        tick();
        check("drop_gnt", 32'(gnt), 32'h8);
        @(negedge CLK);
        req             = '0;
        wdata[3*W +: W] = 8'h6D;
        tick();
        check("drop_q", 32'(Q), 32'h6D);
        tick();
        check("drop_idle", 32'(busy), 32'h0);
        tick();
        check("drop_no_extra", 32'(gnt),  32'h0);
        check("drop_quiet",    32'(busy), 32'h0);

        // Contention with ptr at 3: requester 1 beats 2, then 2 follows
        @(negedge CLK);
        req             = 4'b0110;
        wdata[1*W +: W] = 8'h21;
        wdata[2*W +: W] = 8'h22;
        tick();
        check("cont_gnt1", 32'(gnt), 32'h2);
        @(negedge CLK);
        req = 4'b0100;
        tick();
        check("cont_q1", 32'(Q), 32'h21);
        tick();
        tick();
        check("cont_gnt2", 32'(gnt), 32'h4);
        @(negedge CLK);
        req = '0;
        tick();
        check("cont_q2", 32'(Q), 32'h22);
        tick();
        check("cont_idle", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
